exec_unit: RTL and testbench



---
 rtl/exec_unit.sv | 163 ++++++++++++++++
 tb/tb_exec_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute stage of the 8-bit accumulator CPU: decode, ALU, branch/PC resolve and data memory.
// Optional overflow flag logic is built only when EXEC_OVF_FLAG_EN is defined.
module exec_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] instr,
  input  logic [7:0] pc,
  output logic [1:0] ra_addr,
  output logic [1:0] rb_addr,
  input  logic [7:0] ra_data,
  input  logic [7:0] rb_data,
  input  logic [7:0] r0_data,
  input  logic [7:0] sp_data,
  output logic       out_valid,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] next_pc,
  output logic       halted,
  output logic       overflow
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [3:0] {
    OP_SYS  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR   = 4'h4, OP_XOR = 4'h5, OP_SLT = 4'h6, OP_ADDI = 4'h7,
    OP_J    = 4'h8, OP_JAL = 4'h9, OP_LW  = 4'hA, OP_SW   = 4'hB,
    OP_BEQ  = 4'hC, OP_BNE = 4'hD, OP_SLL = 4'hE, OP_JR   = 4'hF
  } opcode_e;

  opcode_e    opcode;
  logic [7:0] mem [MEM_WORDS];

  logic [7:0] pc_inc, jump_tgt, branch_tgt, imm, add_b, sum, diff, mem_rdata;
  logic       mem_we;
  logic [7:0] mem_waddr, mem_wdata;

  logic       out_valid_q, wr_en_q, halted_q;
  logic [1:0] wr_addr_q;
  logic [7:0] wr_data_q, next_pc_q;
  logic       wr_en_d, halted_d;
  logic [1:0] wr_addr_d;
  logic [7:0] wr_data_d, next_pc_d;

  assign opcode  = opcode_e'(instr[7:4]);
  assign ra_addr = instr[3:2];
  assign rb_addr = instr[1:0];

  always_comb begin
    pc_inc     = pc + 8'd1;
    jump_tgt   = pc_inc + {{4{instr[3]}}, instr[3:0]};
    branch_tgt = pc_inc + r0_data;
    imm        = {{6{instr[1]}}, instr[1:0]};
    add_b      = (opcode == OP_ADDI) ? imm : rb_data;
    sum        = ra_data + add_b;
    diff       = ra_data - rb_data;
    mem_rdata  = mem[rb_data[AW-1:0]];
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = instr[3:2];
    wr_data_d = 8'd0;
    next_pc_d = pc_inc;
    halted_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ra_data;
    mem_wdata = rb_data;
    case (opcode)
      OP_SYS: begin
        if (instr == 8'h00) begin
          halted_d  = 1'b1;
          next_pc_d = pc;
        end
      end
      OP_ADD, OP_ADDI: begin wr_en_d = 1'b1; wr_data_d = sum; end
      OP_SUB:          begin wr_en_d = 1'b1; wr_data_d = diff; end
      OP_AND:          begin wr_en_d = 1'b1; wr_data_d = ra_data & rb_data; end
      OP_OR:           begin wr_en_d = 1'b1; wr_data_d = ra_data | rb_data; end
      OP_XOR:          begin wr_en_d = 1'b1; wr_data_d = ra_data ^ rb_data; end
      OP_SLT: begin
        wr_en_d   = 1'b1;
        wr_data_d = {7'd0, $signed(ra_data) < $signed(rb_data)};
      end
      OP_J: next_pc_d = jump_tgt;
      // jal pushes the return address at SP and post-decrements R3
      OP_JAL: begin
        mem_we    = 1'b1;
        mem_waddr = sp_data;
        mem_wdata = pc_inc;
        wr_en_d   = 1'b1;
        wr_addr_d = 2'd3;
        wr_data_d = sp_data - 8'd1;
        next_pc_d = jump_tgt;
      end
      OP_LW:  begin wr_en_d = 1'b1; wr_data_d = mem_rdata; end
      OP_SW:  mem_we = 1'b1;
      OP_BEQ: if (ra_data == rb_data) next_pc_d = branch_tgt;
      OP_BNE: if (ra_data != rb_data) next_pc_d = branch_tgt;
      OP_SLL: begin wr_en_d = 1'b1; wr_data_d = ra_data << rb_data[2:0]; end
      OP_JR:  next_pc_d = ra_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && in_valid && mem_we) mem[mem_waddr[AW-1:0]] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 2'd0;
      wr_data_q   <= 8'd0;
      next_pc_q   <= 8'd0;
      halted_q    <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      wr_en_q     <= in_valid & wr_en_d;
      if (in_valid) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
        next_pc_q <= next_pc_d;
        halted_q  <= halted_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign next_pc   = next_pc_q;
  assign halted    = halted_q;

`ifdef EXEC_OVF_FLAG_EN
  logic overflow_d, overflow_q;

  always_comb begin
    overflow_d = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDI: overflow_d = (ra_data[7] == add_b[7]) && (sum[7] != ra_data[7]);
      OP_SUB:          overflow_d = (ra_data[7] != rb_data[7]) && (diff[7] != ra_data[7]);
      default:         overflow_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        overflow_q <= 1'b0;
    else if (in_valid) overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed scenarios with literal expectations plus
// randomized instructions compared every cycle against an arithmetic reference model.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] instr = 8'h00, pc = 8'h00;
  logic [7:0] ra_data = 8'h00, rb_data = 8'h00, r0_data = 8'h00, sp_data = 8'h00;
  logic [1:0] ra_addr, rb_addr, wr_addr;
  logic       out_valid, wr_en, halted, overflow;
  logic [7:0] wr_data, next_pc;

  int checks = 0;
  int errors = 0;
  bit checkOn = 1'b0;

  exec_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr), .pc(pc),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .r0_data(r0_data), .sp_data(sp_data), .out_valid(out_valid), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .next_pc(next_pc), .halted(halted),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

`ifdef EXEC_OVF_FLAG_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct packed {
    logic       wr_en;
    logic       wr_chk;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] next_pc;
    logic       halted;
    logic       ovf;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
  } res_t;

  // Reference behaviour of one instruction, from the ISA rules with integer arithmetic.
  function automatic res_t modelEval(input logic [7:0] ins, input logic [7:0] p,
                                     input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] r0, input logic [7:0] sp,
                                     input logic [7:0] mrd, input bit mok);
    res_t r;
    int sa, sb, off4, imm, s;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    off4 = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
    imm  = ins[1] ? int'(ins[1:0]) - 4 : int'(ins[1:0]);
    r = '0;
    r.next_pc = 8'(int'(p) + 1);
    r.wr_addr = ins[3:2];
    r.wr_chk  = 1'b1;
    case (ins[7:4])
      4'h0: if (ins == 8'h00) begin r.halted = 1'b1; r.next_pc = p; end
      4'h1: begin s = sa + sb; r.wr_en = 1'b1; r.wr_data = 8'(s); r.ovf = (s > 127) || (s < -128); end
      4'h2: begin s = sa - sb; r.wr_en = 1'b1; r.wr_data = 8'(s); r.ovf = (s > 127) || (s < -128); end
      4'h3: begin r.wr_en = 1'b1; r.wr_data = a & b; end
      4'h4: begin r.wr_en = 1'b1; r.wr_data = a | b; end
      4'h5: begin r.wr_en = 1'b1; r.wr_data = a ^ b; end
      4'h6: begin r.wr_en = 1'b1; r.wr_data = (sa < sb) ? 8'd1 : 8'd0; end
      4'h7: begin s = sa + imm; r.wr_en = 1'b1; r.wr_data = 8'(s); r.ovf = (s > 127) || (s < -128); end
      4'h8: r.next_pc = 8'(int'(p) + 1 + off4);
      4'h9: begin
        r.mem_we = 1'b1; r.mem_addr = sp; r.mem_data = 8'(int'(p) + 1);
        r.wr_en = 1'b1; r.wr_addr = 2'd3; r.wr_data = 8'(int'(sp) - 1);
        r.next_pc = 8'(int'(p) + 1 + off4);
      end
      4'hA: begin r.wr_en = 1'b1; r.wr_data = mrd; r.wr_chk = mok; end
      4'hB: begin r.mem_we = 1'b1; r.mem_addr = a; r.mem_data = b; end
      4'hC: if (a == b) r.next_pc = 8'(int'(p) + 1 + int'(r0));
      4'hD: if (a != b) r.next_pc = 8'(int'(p) + 1 + int'(r0));
      4'hE: begin r.wr_en = 1'b1; r.wr_data = 8'(int'(a) * (1 << int'(b[2:0]))); end
      default: r.next_pc = a;
    endcase
    if (!OVF_ON) r.ovf = 1'b0;
    return r;
  endfunction

  logic [7:0] memModel [256];
  bit         memOk [256];
  logic       expValid = 1'b0, expWrEn = 1'b0, expWrChk = 1'b0, expHalted = 1'b0, expOvf = 1'b0;
  logic [1:0] expWrAddr = 2'd0;
  logic [7:0] expWrData = 8'd0, expNextPc = 8'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expValid <= 1'b0; expWrEn <= 1'b0; expWrChk <= 1'b1; expWrAddr <= 2'd0;
      expWrData <= 8'd0; expNextPc <= 8'd0; expHalted <= 1'b0; expOvf <= 1'b0;
    end else begin
      expValid <= in_valid;
      expWrEn  <= 1'b0;
      if (in_valid) begin : accept
        res_t r;
        r = modelEval(instr, pc, ra_data, rb_data, r0_data, sp_data,
                      memModel[rb_data], memOk[rb_data]);
        expWrEn   <= r.wr_en;
        expWrChk  <= r.wr_chk;
        expWrAddr <= r.wr_addr;
        expWrData <= r.wr_data;
        expNextPc <= r.next_pc;
        expHalted <= r.halted;
        expOvf    <= r.ovf;
        if (r.mem_we) begin
          memModel[r.mem_addr] <= r.mem_data;
          memOk[r.mem_addr]    <= 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("ra_addr", {6'd0, ra_addr}, {6'd0, instr[3:2]});
      checkOutput("rb_addr", {6'd0, rb_addr}, {6'd0, instr[1:0]});
      checkOutput("out_valid", {7'd0, out_valid}, {7'd0, expValid});
      checkOutput("wr_en", {7'd0, wr_en}, {7'd0, expWrEn});
      checkOutput("next_pc", next_pc, expNextPc);
      checkOutput("halted", {7'd0, halted}, {7'd0, expHalted});
      checkOutput("overflow", {7'd0, overflow}, {7'd0, expOvf});
      if (expWrEn) checkOutput("wr_addr", {6'd0, wr_addr}, {6'd0, expWrAddr});
      if (expWrEn && expWrChk) checkOutput("wr_data", wr_data, expWrData);
    end
  end

  // Drives one accepted instruction at posedge+1 and returns at the next posedge+1.
  task automatic applyStimulus(input logic [7:0] ins, input logic [7:0] p,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] r0, input logic [7:0] sp);
    in_valid = 1'b1; instr = ins; pc = p;
    ra_data = a; rb_data = b; r0_data = r0; sp_data = sp;
    @(posedge clk); #1;
  endtask

  task automatic idleCycle();
    in_valid = 1'b0;
    instr = 8'($urandom); pc = 8'($urandom);
    ra_data = 8'($urandom); rb_data = 8'($urandom);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] pickOperand();
    return ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
  endfunction

  initial begin
    #1 checkOn = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    checkOutput("reset out_valid", {7'd0, out_valid}, 8'd0);
    checkOutput("reset next_pc", next_pc, 8'd0);

    applyStimulus(8'h16, 8'h10, 8'h7F, 8'h01, 8'h00, 8'h00);
    checkOutput("add wr_en", {7'd0, wr_en}, 8'd1);
    checkOutput("add wr_addr", {6'd0, wr_addr}, 8'd1);
    checkOutput("add wr_data", wr_data, 8'h80);
    checkOutput("add overflow", {7'd0, overflow}, {7'd0, OVF_ON});
    checkOutput("add next_pc", next_pc, 8'h11);

    applyStimulus(8'hB1, 8'h11, 8'h20, 8'hA5, 8'h00, 8'h00);
    checkOutput("sw wr_en", {7'd0, wr_en}, 8'd0);
    applyStimulus(8'hA9, 8'h12, 8'h00, 8'h20, 8'h00, 8'h00);
    checkOutput("lw wr_addr", {6'd0, wr_addr}, 8'd2);
    checkOutput("lw wr_data", wr_data, 8'hA5);

    applyStimulus(8'hC1, 8'h40, 8'h33, 8'h33, 8'h05, 8'h00);
    checkOutput("beq next_pc", next_pc, 8'h46);
    applyStimulus(8'hD1, 8'h40, 8'h33, 8'h33, 8'h05, 8'h00);
    checkOutput("bne next_pc", next_pc, 8'h41);

    applyStimulus(8'h9E, 8'h08, 8'h00, 8'h00, 8'h00, 8'hFF);
    checkOutput("jal wr_addr", {6'd0, wr_addr}, 8'd3);
    checkOutput("jal wr_data", wr_data, 8'hFE);
    checkOutput("jal next_pc", next_pc, 8'h07);
    applyStimulus(8'hA0, 8'h07, 8'h00, 8'hFF, 8'h00, 8'hFE);
    checkOutput("jal push", wr_data, 8'h09);
    applyStimulus(8'hF4, 8'h08, 8'h09, 8'h00, 8'h00, 8'hFE);
    checkOutput("jr next_pc", next_pc, 8'h09);

    applyStimulus(8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("halt halted", {7'd0, halted}, 8'd1);
    checkOutput("halt wr_en", {7'd0, wr_en}, 8'd0);
    checkOutput("halt next_pc", next_pc, 8'h22);
    applyStimulus(8'h61, 8'h23, 8'hFF, 8'h01, 8'h00, 8'h00);
    checkOutput("slt wr_data", wr_data, 8'h01);
    idleCycle();
    checkOutput("idle out_valid", {7'd0, out_valid}, 8'd0);
    checkOutput("idle hold next_pc", next_pc, 8'h24);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idleCycle();
      else applyStimulus(8'($urandom), 8'($urandom), pickOperand(), pickOperand(),
                         8'($urandom), pickOperand());
    end

    // Reset in the middle of a cycle must clear the registered outputs at once.
    applyStimulus(8'h16, 8'h30, 8'h7F, 8'h01, 8'h00, 8'h00);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", {7'd0, out_valid}, 8'd0);
    checkOutput("async rst wr_en", {7'd0, wr_en}, 8'd0);
    checkOutput("async rst wr_data", wr_data, 8'd0);
    checkOutput("async rst next_pc", next_pc, 8'd0);
    checkOutput("async rst overflow", {7'd0, overflow}, 8'd0);
    in_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post rst out_valid", {7'd0, out_valid}, 8'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
